// File: rtl/dcache_axi_pkg.sv
// Shared AXI encodings and write-FSM state type for the dcache AXI bridge.
// Optional feature macro used by the bridge: DCACHE_AXI_RAW_ORDER_EN.
package dcache_axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_BURST = 1'b1
    } wr_state_e;

    // Width of one queued W beat {last, strb, data} for a given data width.
    function automatic int unsigned wbeat_bits(input int unsigned data_w);
        return 1 + (data_w / 8) + data_w;
    endfunction

endpackage

// File: rtl/dcache_axi_fifo.sv
// Generic synchronous FIFO with async active-low reset; DEPTH must be a power of 2.
// A pop frees its slot for a push in the same cycle, so a full FIFO keeps streaming.
module dcache_axi_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage carries no reset so it maps onto plain memory.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dcache_axi_bridge.sv
// Dcache request port to AXI4 master: registered AW/AR slots, W beat FIFO, outstanding limits.
// Define DCACHE_AXI_RAW_ORDER_EN to hold reads until all writes have completed.
module dcache_axi_bridge
    import dcache_axi_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned WBUF_DEPTH = 4,
    parameter int unsigned MAX_OUT    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  inport_valid_i,
    input  logic                  inport_write_i,
    input  logic [31:0]           inport_addr_i,
    input  logic [ID_W-1:0]       inport_id_i,
    input  logic [7:0]            inport_len_i,
    input  logic [1:0]            inport_burst_i,
    input  logic [DATA_W-1:0]     inport_wdata_i,
    input  logic [DATA_W/8-1:0]   inport_wstrb_i,
    output logic                  inport_accept_o,
    input  logic                  inport_bready_i,
    input  logic                  inport_rready_i,
    output logic                  inport_bvalid_o,
    output logic [1:0]            inport_bresp_o,
    output logic [ID_W-1:0]       inport_bid_o,
    output logic                  inport_rvalid_o,
    output logic [DATA_W-1:0]     inport_rdata_o,
    output logic [1:0]            inport_rresp_o,
    output logic [ID_W-1:0]       inport_rid_o,
    output logic                  inport_rlast_o,
    output logic                  outport_awvalid_o,
    output logic [31:0]           outport_awaddr_o,
    output logic [ID_W-1:0]       outport_awid_o,
    output logic [7:0]            outport_awlen_o,
    output logic [1:0]            outport_awburst_o,
    input  logic                  outport_awready_i,
    output logic                  outport_wvalid_o,
    output logic [DATA_W-1:0]     outport_wdata_o,
    output logic [DATA_W/8-1:0]   outport_wstrb_o,
    output logic                  outport_wlast_o,
    input  logic                  outport_wready_i,
    input  logic                  outport_bvalid_i,
    input  logic [1:0]            outport_bresp_i,
    input  logic [ID_W-1:0]       outport_bid_i,
    output logic                  outport_bready_o,
    output logic                  outport_arvalid_o,
    output logic [31:0]           outport_araddr_o,
    output logic [ID_W-1:0]       outport_arid_o,
    output logic [7:0]            outport_arlen_o,
    output logic [1:0]            outport_arburst_o,
    input  logic                  outport_arready_i,
    input  logic                  outport_rvalid_i,
    input  logic [DATA_W-1:0]     outport_rdata_i,
    input  logic [1:0]            outport_rresp_i,
    input  logic [ID_W-1:0]       outport_rid_i,
    input  logic                  outport_rlast_i,
    output logic                  outport_rready_o
);
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);
    localparam int unsigned WBEAT_W = wbeat_bits(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    typedef struct packed {
        logic              last;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } wbeat_t;

    wr_state_e        state_q;
    logic [7:0]       beats_left_q;

    logic             aw_valid_q;
    logic [31:0]      aw_addr_q;
    logic [ID_W-1:0]  aw_id_q;
    logic [7:0]       aw_len_q;
    logic [1:0]       aw_burst_q;

    logic             ar_valid_q;
    logic [31:0]      ar_addr_q;
    logic [ID_W-1:0]  ar_id_q;
    logic [7:0]       ar_len_q;
    logic [1:0]       ar_burst_q;

    logic [CNT_W-1:0] wr_out_q, wr_out_d;
    logic [CNT_W-1:0] rd_out_q, rd_out_d;

    logic             fifo_full, fifo_empty;
    logic             w_pop;
    wbeat_t           push_beat, head_beat;
    logic [WBEAT_W-1:0] head_bits;

    logic b_hs, r_last_hs;
    logic aw_free, ar_free, fifo_room, wr_room, rd_room;
    logic raw_block;
    logic wr_accept, wr_first, rd_accept;

    assign b_hs      = outport_bvalid_i && inport_bready_i;
    assign r_last_hs = outport_rvalid_i && inport_rready_i && outport_rlast_i;
    assign w_pop     = !fifo_empty && outport_wready_i;

    // Slots and counters may be consumed and refilled in the same cycle.
    assign aw_free   = !aw_valid_q || outport_awready_i;
    assign ar_free   = !ar_valid_q || outport_arready_i;
    assign fifo_room = !fifo_full || w_pop;
    assign wr_room   = (wr_out_q < CNT_MAX) || b_hs;
    assign rd_room   = (rd_out_q < CNT_MAX) || r_last_hs;

`ifdef DCACHE_AXI_RAW_ORDER_EN
    assign raw_block = (state_q == WR_BURST) || aw_valid_q || !fifo_empty || (wr_out_q != '0);
`else
    assign raw_block = 1'b0;
`endif

    always_comb begin
        wr_accept = 1'b0;
        rd_accept = 1'b0;
        if (rst_ni && inport_valid_i) begin
            if (state_q == WR_IDLE) begin
                wr_accept = inport_write_i && aw_free && fifo_room && wr_room;
                rd_accept = !inport_write_i && ar_free && rd_room && !raw_block;
            end else begin
                wr_accept = inport_write_i && fifo_room;
            end
        end
    end

    assign wr_first        = wr_accept && (state_q == WR_IDLE);
    assign inport_accept_o = rst_ni && (wr_accept || rd_accept);

    always_comb begin
        push_beat.data = inport_wdata_i;
        push_beat.strb = inport_wstrb_i;
        push_beat.last = (state_q == WR_IDLE) ? (inport_len_i == 8'd0) : (beats_left_q == 8'd1);
    end

    // Write FSM together with the AW slot it fills.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= WR_IDLE;
            beats_left_q <= '0;
            aw_valid_q   <= 1'b0;
            aw_addr_q    <= '0;
            aw_id_q      <= '0;
            aw_len_q     <= '0;
            aw_burst_q   <= '0;
        end else begin
            if (aw_valid_q && outport_awready_i) aw_valid_q <= 1'b0;
            case (state_q)
                WR_IDLE: begin
                    if (wr_accept) begin
                        aw_valid_q <= 1'b1;
                        aw_addr_q  <= inport_addr_i;
                        aw_id_q    <= inport_id_i;
                        aw_len_q   <= inport_len_i;
                        aw_burst_q <= inport_burst_i;
                        if (inport_len_i != 8'd0) begin
                            beats_left_q <= inport_len_i;
                            state_q      <= WR_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    if (wr_accept) begin
                        beats_left_q <= beats_left_q - 8'd1;
                        if (beats_left_q == 8'd1) state_q <= WR_IDLE;
                    end
                end
                default: state_q <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            ar_burst_q <= '0;
        end else begin
            if (rd_accept) begin
                ar_valid_q <= 1'b1;
                ar_addr_q  <= inport_addr_i;
                ar_id_q    <= inport_id_i;
                ar_len_q   <= inport_len_i;
                ar_burst_q <= inport_burst_i;
            end else if (ar_valid_q && outport_arready_i) begin
                ar_valid_q <= 1'b0;
            end
        end
    end

    // Decrements are gated on a non-zero count so a stray response cannot wrap.
    always_comb begin
        wr_out_d = wr_out_q;
        if (wr_first && !(b_hs && wr_out_q != '0))      wr_out_d = wr_out_q + 1'b1;
        else if (!wr_first && b_hs && wr_out_q != '0)   wr_out_d = wr_out_q - 1'b1;

        rd_out_d = rd_out_q;
        if (rd_accept && !(r_last_hs && rd_out_q != '0))      rd_out_d = rd_out_q + 1'b1;
        else if (!rd_accept && r_last_hs && rd_out_q != '0)   rd_out_d = rd_out_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_out_q <= '0;
            rd_out_q <= '0;
        end else begin
            wr_out_q <= wr_out_d;
            rd_out_q <= rd_out_d;
        end
    end

    dcache_axi_fifo #(
        .WIDTH (WBEAT_W),
        .DEPTH (WBUF_DEPTH)
    ) u_wfifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wr_accept),
        .data_i  (push_beat),
        .pop_i   (outport_wready_i),
        .data_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_beat = head_bits;

    assign outport_awvalid_o = aw_valid_q;
    assign outport_awaddr_o  = aw_addr_q;
    assign outport_awid_o    = aw_id_q;
    assign outport_awlen_o   = aw_len_q;
    assign outport_awburst_o = aw_burst_q;

    assign outport_wvalid_o  = !fifo_empty;
    assign outport_wdata_o   = head_beat.data;
    assign outport_wstrb_o   = head_beat.strb;
    assign outport_wlast_o   = head_beat.last;

    assign outport_arvalid_o = ar_valid_q;
    assign outport_araddr_o  = ar_addr_q;
    assign outport_arid_o    = ar_id_q;
    assign outport_arlen_o   = ar_len_q;
    assign outport_arburst_o = ar_burst_q;

    assign outport_bready_o  = inport_bready_i;
    assign inport_bvalid_o   = outport_bvalid_i;
    assign inport_bresp_o    = outport_bresp_i;
    assign inport_bid_o      = outport_bid_i;

    assign outport_rready_o  = inport_rready_i;
    assign inport_rvalid_o   = outport_rvalid_i;
    assign inport_rdata_o    = outport_rdata_i;
    assign inport_rresp_o    = outport_rresp_i;
    assign inport_rid_o      = outport_rid_i;
    assign inport_rlast_o    = outport_rlast_i;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Scoreboard bench for dcache_axi_bridge (DATA_W=32, ID_W=4, WBUF_DEPTH=4, MAX_OUT=2).
// Directed stimulus pushes expected AXI traffic; negedge monitors pop and compare.
module tb_dcache_axi_bridge;

    logic        clk;
    logic        rst_n;
    logic        inport_valid_i, inport_write_i;
    logic [31:0] inport_addr_i;
    logic [3:0]  inport_id_i;
    logic [7:0]  inport_len_i;
    logic [1:0]  inport_burst_i;
    logic [31:0] inport_wdata_i;
    logic [3:0]  inport_wstrb_i;
    logic        inport_accept_o;
    logic        inport_bready_i, inport_rready_i;
    logic        inport_bvalid_o;
    logic [1:0]  inport_bresp_o;
    logic [3:0]  inport_bid_o;
    logic        inport_rvalid_o;
    logic [31:0] inport_rdata_o;
    logic [1:0]  inport_rresp_o;
    logic [3:0]  inport_rid_o;
    logic        inport_rlast_o;
    logic        outport_awvalid_o;
    logic [31:0] outport_awaddr_o;
    logic [3:0]  outport_awid_o;
    logic [7:0]  outport_awlen_o;
    logic [1:0]  outport_awburst_o;
    logic        outport_awready_i;
    logic        outport_wvalid_o;
    logic [31:0] outport_wdata_o;
    logic [3:0]  outport_wstrb_o;
    logic        outport_wlast_o;
    logic        outport_wready_i;
    logic        outport_bvalid_i;
    logic [1:0]  outport_bresp_i;
    logic [3:0]  outport_bid_i;
    logic        outport_bready_o;
    logic        outport_arvalid_o;
    logic [31:0] outport_araddr_o;
    logic [3:0]  outport_arid_o;
    logic [7:0]  outport_arlen_o;
    logic [1:0]  outport_arburst_o;
    logic        outport_arready_i;
    logic        outport_rvalid_i;
    logic [31:0] outport_rdata_i;
    logic [1:0]  outport_rresp_i;
    logic [3:0]  outport_rid_i;
    logic        outport_rlast_i;
    logic        outport_rready_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] aw_q[$];
    logic [63:0] w_q[$];
    logic [63:0] ar_q[$];
    logic [63:0] b_q[$];
    logic [63:0] r_q[$];

    dcache_axi_bridge #(
        .DATA_W(32), .ID_W(4), .WBUF_DEPTH(4), .MAX_OUT(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .inport_valid_i(inport_valid_i), .inport_write_i(inport_write_i),
        .inport_addr_i(inport_addr_i), .inport_id_i(inport_id_i),
        .inport_len_i(inport_len_i), .inport_burst_i(inport_burst_i),
        .inport_wdata_i(inport_wdata_i), .inport_wstrb_i(inport_wstrb_i),
        .inport_accept_o(inport_accept_o),
        .inport_bready_i(inport_bready_i), .inport_rready_i(inport_rready_i),
        .inport_bvalid_o(inport_bvalid_o), .inport_bresp_o(inport_bresp_o), .inport_bid_o(inport_bid_o),
        .inport_rvalid_o(inport_rvalid_o), .inport_rdata_o(inport_rdata_o), .inport_rresp_o(inport_rresp_o),
        .inport_rid_o(inport_rid_o), .inport_rlast_o(inport_rlast_o),
        .outport_awvalid_o(outport_awvalid_o), .outport_awaddr_o(outport_awaddr_o),
        .outport_awid_o(outport_awid_o), .outport_awlen_o(outport_awlen_o),
        .outport_awburst_o(outport_awburst_o), .outport_awready_i(outport_awready_i),
        .outport_wvalid_o(outport_wvalid_o), .outport_wdata_o(outport_wdata_o),
        .outport_wstrb_o(outport_wstrb_o), .outport_wlast_o(outport_wlast_o),
        .outport_wready_i(outport_wready_i),
        .outport_bvalid_i(outport_bvalid_i), .outport_bresp_i(outport_bresp_i),
        .outport_bid_i(outport_bid_i), .outport_bready_o(outport_bready_o),
        .outport_arvalid_o(outport_arvalid_o), .outport_araddr_o(outport_araddr_o),
        .outport_arid_o(outport_arid_o), .outport_arlen_o(outport_arlen_o),
        .outport_arburst_o(outport_arburst_o), .outport_arready_i(outport_arready_i),
        .outport_rvalid_i(outport_rvalid_i), .outport_rdata_i(outport_rdata_i),
        .outport_rresp_i(outport_rresp_i), .outport_rid_i(outport_rid_i),
        .outport_rlast_i(outport_rlast_i), .outport_rready_o(outport_rready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake with no expected entry", name);
    endtask

    // ---------------- monitors ----------------
    logic [63:0] aw_exp, w_exp, ar_exp, b_exp, r_exp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (outport_awvalid_o && outport_awready_i) begin
                $display("AW addr=%h id=%h len=%0d burst=%0d", outport_awaddr_o, outport_awid_o, outport_awlen_o, outport_awburst_o);
                if (aw_q.size() == 0) unexpected("aw_unexpected");
                else begin
                    aw_exp = aw_q.pop_front();
                    chk("aw_fields", {18'd0, outport_awaddr_o, outport_awid_o, outport_awlen_o, outport_awburst_o}, aw_exp);
                end
            end
            if (outport_wvalid_o && outport_wready_i) begin
                $display("W  data=%h strb=%h last=%0d", outport_wdata_o, outport_wstrb_o, outport_wlast_o);
                if (w_q.size() == 0) unexpected("w_unexpected");
                else begin
                    w_exp = w_q.pop_front();
                    chk("w_fields", {27'd0, outport_wlast_o, outport_wstrb_o, outport_wdata_o}, w_exp);
                end
            end
            if (outport_arvalid_o && outport_arready_i) begin
                $display("AR addr=%h id=%h len=%0d burst=%0d", outport_araddr_o, outport_arid_o, outport_arlen_o, outport_arburst_o);
                if (ar_q.size() == 0) unexpected("ar_unexpected");
                else begin
                    ar_exp = ar_q.pop_front();
                    chk("ar_fields", {18'd0, outport_araddr_o, outport_arid_o, outport_arlen_o, outport_arburst_o}, ar_exp);
                end
            end
            if (inport_bvalid_o && inport_bready_i) begin
                $display("B  resp=%0d id=%h", inport_bresp_o, inport_bid_o);
                if (b_q.size() == 0) unexpected("b_unexpected");
                else begin
                    b_exp = b_q.pop_front();
                    chk("b_fields", {58'd0, inport_bresp_o, inport_bid_o}, b_exp);
                    chk("b_ready_pass", 64'(outport_bready_o), 64'(inport_bready_i));
                end
            end
            if (inport_rvalid_o && inport_rready_i) begin
                $display("R  data=%h resp=%0d id=%h last=%0d", inport_rdata_o, inport_rresp_o, inport_rid_o, inport_rlast_o);
                if (r_q.size() == 0) unexpected("r_unexpected");
                else begin
                    r_exp = r_q.pop_front();
                    chk("r_fields", {25'd0, inport_rdata_o, inport_rresp_o, inport_rid_o, inport_rlast_o}, r_exp);
                    chk("r_ready_pass", 64'(outport_rready_o), 64'(inport_rready_i));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input logic wr, input logic [31:0] addr, input logic [3:0] id,
                             input logic [7:0] len, input logic [31:0] data, input logic [3:0] strb,
                             input logic last, input logic first, output int waited);
        bit ok;
        inport_valid_i = 1'b1;
        inport_write_i = wr;
        inport_addr_i  = addr;
        inport_id_i    = id;
        inport_len_i   = len;
        inport_burst_i = 2'b01;
        inport_wdata_i = data;
        inport_wstrb_i = strb;
        waited = 0;
        ok = 1'b0;
        forever begin
            @(negedge clk);
            if (inport_accept_o) begin
                ok = 1'b1;
                break;
            end
            waited++;
            if (waited > 40) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: addr %h not accepted after %0d cycles", addr, waited);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            if (wr) begin
                if (first) aw_q.push_back({18'd0, addr, id, len, 2'b01});
                w_q.push_back({27'd0, last, strb, data});
            end else begin
                ar_q.push_back({18'd0, addr, id, len, 2'b01});
            end
        end
        @(posedge clk);
        #1;
        inport_valid_i = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] id);
        outport_bvalid_i = 1'b1;
        outport_bresp_i  = 2'b00;
        outport_bid_i    = id;
        b_q.push_back({58'd0, 2'b00, id});
        @(negedge clk);
        @(posedge clk);
        #1;
        outport_bvalid_i = 1'b0;
    endtask

    task automatic send_r(input logic [3:0] id, input logic [31:0] data, input logic last);
        outport_rvalid_i = 1'b1;
        outport_rdata_i  = data;
        outport_rresp_i  = 2'b00;
        outport_rid_i    = id;
        outport_rlast_i  = last;
        r_q.push_back({25'd0, data, 2'b00, id, last});
        @(negedge clk);
        @(posedge clk);
        #1;
        outport_rvalid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        rst_n = 1'b0;
        inport_valid_i = 1'b1; inport_write_i = 1'b1;
        inport_addr_i = 32'h0; inport_id_i = 4'h0; inport_len_i = 8'h0; inport_burst_i = 2'b01;
        inport_wdata_i = 32'h0; inport_wstrb_i = 4'h0;
        inport_bready_i = 1'b1; inport_rready_i = 1'b1;
        outport_awready_i = 1'b1; outport_wready_i = 1'b1; outport_arready_i = 1'b1;
        outport_bvalid_i = 1'b0; outport_bresp_i = 2'b00; outport_bid_i = 4'h0;
        outport_rvalid_i = 1'b0; outport_rdata_i = 32'h0; outport_rresp_i = 2'b00;
        outport_rid_i = 4'h0; outport_rlast_i = 1'b0;

        // Reset state, with a request pending to show accept is forced low.
        @(negedge clk);
        chk("rst_accept",  64'(inport_accept_o),   64'd0);
        chk("rst_awvalid", 64'(outport_awvalid_o), 64'd0);
        chk("rst_wvalid",  64'(outport_wvalid_o),  64'd0);
        chk("rst_arvalid", 64'(outport_arvalid_o), 64'd0);
        @(posedge clk); #1;
        inport_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(1);

        // Single write: accepted at once, AW and W visible the next cycle.
        send_beat(1'b1, 32'h0000_1000, 4'h3, 8'd0, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, w);
        chk("single_wait", 64'(w), 64'd0);
        @(negedge clk);
        chk("single_awvalid_c1", 64'(outport_awvalid_o), 64'd1);
        chk("single_wvalid_c1",  64'(outport_wvalid_o),  64'd1);
        @(posedge clk); #1;
        send_b(4'h3);
        idle_cycles(2);

        // Burst of 4 with W stalled for 6 cycles; a following write waits on the full FIFO.
        outport_wready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_beat(1'b1, 32'h0000_3000, 4'h2, 8'd3, 32'hB000_0000 + 32'(i), 4'hF,
                      (i == 3), (i == 0), w);
            chk("burst_beat_wait", 64'(w), 64'd0);
        end
        inport_valid_i = 1'b1; inport_write_i = 1'b1;
        inport_addr_i = 32'h0000_4000; inport_id_i = 4'h4; inport_len_i = 8'd0;
        inport_wdata_i = 32'h4444_0000; inport_wstrb_i = 4'h3;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("fifo_full_stall", 64'(inport_accept_o), 64'd0);
            @(posedge clk); #1;
        end
        outport_wready_i = 1'b1;
        @(negedge clk);
        chk("pop_before_push", 64'(inport_accept_o), 64'd1);
        if (inport_accept_o) begin
            aw_q.push_back({18'd0, 32'h0000_4000, 4'h4, 8'd0, 2'b01});
            w_q.push_back({27'd0, 1'b1, 4'h3, 32'h4444_0000});
        end
        @(posedge clk); #1;
        inport_valid_i = 1'b0;
        idle_cycles(6);
        send_b(4'h2);
        send_b(4'h4);
        idle_cycles(2);

        // Outstanding limit of 2: third write waits for a B, accepted in that cycle.
        send_beat(1'b1, 32'h0000_7000, 4'h1, 8'd0, 32'h7000_0001, 4'hF, 1'b1, 1'b1, w);
        chk("out_w1_wait", 64'(w), 64'd0);
        send_beat(1'b1, 32'h0000_7004, 4'h2, 8'd0, 32'h7000_0002, 4'hF, 1'b1, 1'b1, w);
        chk("out_w2_wait", 64'(w), 64'd0);
        inport_valid_i = 1'b1; inport_write_i = 1'b1;
        inport_addr_i = 32'h0000_7008; inport_id_i = 4'h3; inport_len_i = 8'd0;
        inport_wdata_i = 32'h7000_0003; inport_wstrb_i = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("out_limit_hold", 64'(inport_accept_o), 64'd0);
            @(posedge clk); #1;
        end
        outport_bvalid_i = 1'b1; outport_bresp_i = 2'b00; outport_bid_i = 4'h1;
        b_q.push_back({58'd0, 2'b00, 4'h1});
        @(negedge clk);
        chk("out_limit_release", 64'(inport_accept_o), 64'd1);
        if (inport_accept_o) begin
            aw_q.push_back({18'd0, 32'h0000_7008, 4'h3, 8'd0, 2'b01});
            w_q.push_back({27'd0, 1'b1, 4'hF, 32'h7000_0003});
        end
        @(posedge clk); #1;
        inport_valid_i = 1'b0;
        outport_bvalid_i = 1'b0;
        idle_cycles(2);
        send_b(4'h2);
        send_b(4'h3);
        idle_cycles(2);

        // Read with arready delayed 3 cycles; read count drops only on rlast.
        outport_arready_i = 1'b0;
        send_beat(1'b0, 32'h0000_2000, 4'h5, 8'd7, 32'h0, 4'h0, 1'b0, 1'b0, w);
        chk("rd_a_wait", 64'(w), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ar_hold_valid", 64'(outport_arvalid_o), 64'd1);
            chk("ar_hold_addr",  64'(outport_araddr_o),  64'h2000);
            @(posedge clk); #1;
        end
        outport_arready_i = 1'b1;
        send_beat(1'b0, 32'h0000_2100, 4'h6, 8'd0, 32'h0, 4'h0, 1'b0, 1'b0, w);
        chk("rd_b_wait", 64'(w), 64'd0);
        inport_valid_i = 1'b1; inport_write_i = 1'b0;
        inport_addr_i = 32'h0000_2200; inport_id_i = 4'h7; inport_len_i = 8'd0;
        for (int i = 0; i < 8; i++) begin
            outport_rvalid_i = 1'b1; outport_rdata_i = 32'hA000_0000 + 32'(i);
            outport_rresp_i = 2'b00; outport_rid_i = 4'h5; outport_rlast_i = (i == 7);
            r_q.push_back({25'd0, 32'hA000_0000 + 32'(i), 2'b00, 4'h5, (i == 7)});
            @(negedge clk);
            chk("rd_out_on_rlast", 64'(inport_accept_o), 64'(i == 7));
            if (i == 7 && inport_accept_o)
                ar_q.push_back({18'd0, 32'h0000_2200, 4'h7, 8'd0, 2'b01});
            @(posedge clk); #1;
        end
        inport_valid_i = 1'b0;
        outport_rvalid_i = 1'b0;
        idle_cycles(2);
        send_r(4'h6, 32'h6666_6666, 1'b1);
        send_r(4'h7, 32'h7777_7777, 1'b1);
        idle_cycles(2);

        // Write followed immediately by a read of the same address.
        send_beat(1'b1, 32'h0000_5000, 4'h8, 8'd0, 32'h5555_AAAA, 4'hF, 1'b1, 1'b1, w);
        chk("raw_wr_wait", 64'(w), 64'd0);
        inport_valid_i = 1'b1; inport_write_i = 1'b0;
        inport_addr_i = 32'h0000_5000; inport_id_i = 4'h9; inport_len_i = 8'd0;
`ifdef DCACHE_AXI_RAW_ORDER_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("raw_hold", 64'(inport_accept_o), 64'd0);
            @(posedge clk); #1;
        end
        outport_bvalid_i = 1'b1; outport_bresp_i = 2'b00; outport_bid_i = 4'h8;
        b_q.push_back({58'd0, 2'b00, 4'h8});
        @(negedge clk);
        chk("raw_hold_bcycle", 64'(inport_accept_o), 64'd0);
        @(posedge clk); #1;
        outport_bvalid_i = 1'b0;
        @(negedge clk);
        chk("raw_release", 64'(inport_accept_o), 64'd1);
`else
        @(negedge clk);
        chk("rw_independent", 64'(inport_accept_o), 64'd1);
`endif
        if (inport_accept_o) ar_q.push_back({18'd0, 32'h0000_5000, 4'h9, 8'd0, 2'b01});
        @(posedge clk); #1;
        inport_valid_i = 1'b0;
`ifndef DCACHE_AXI_RAW_ORDER_EN
        send_b(4'h8);
`endif
        idle_cycles(1);
        send_r(4'h9, 32'h5555_AAAA, 1'b1);
        idle_cycles(2);

        // Reset asserted on beat 2 of a 4-beat burst.
        outport_awready_i = 1'b0;
        outport_wready_i  = 1'b0;
        send_beat(1'b1, 32'h0000_8000, 4'hA, 8'd3, 32'h8000_0000, 4'hF, 1'b0, 1'b1, w);
        send_beat(1'b1, 32'h0000_8000, 4'hA, 8'd3, 32'h8000_0001, 4'hF, 1'b0, 1'b0, w);
        inport_valid_i = 1'b1; inport_write_i = 1'b1; inport_wdata_i = 32'h8000_0002;
        #2;
        chk("pre_rst_awvalid", 64'(outport_awvalid_o), 64'd1);
        chk("pre_rst_wvalid",  64'(outport_wvalid_o),  64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_awvalid", 64'(outport_awvalid_o), 64'd0);
        chk("async_rst_wvalid",  64'(outport_wvalid_o),  64'd0);
        chk("async_rst_arvalid", 64'(outport_arvalid_o), 64'd0);
        chk("async_rst_accept",  64'(inport_accept_o),   64'd0);
        aw_q.delete();
        w_q.delete();
        inport_valid_i = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        outport_awready_i = 1'b1;
        outport_wready_i  = 1'b1;
        idle_cycles(1);
        send_beat(1'b1, 32'h0000_9000, 4'hB, 8'd0, 32'h9999_0000, 4'hC, 1'b1, 1'b1, w);
        chk("post_rst_wait", 64'(w), 64'd0);
        idle_cycles(2);
        send_b(4'hB);
        idle_cycles(4);

        chk("aw_queue_drained", 64'(aw_q.size()), 64'd0);
        chk("w_queue_drained",  64'(w_q.size()),  64'd0);
        chk("ar_queue_drained", 64'(ar_q.size()), 64'd0);
        chk("b_queue_drained",  64'(b_q.size()),  64'd0);
        chk("r_queue_drained",  64'(r_q.size()),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
